// File: rtl/fft_ram_reader_if.sv
// RAM read port plus output stream of the FFT RAM reader.
// master = reader side, slave = RAM/downstream side.
interface fft_ram_reader_if #(
    parameter int DWL = 16,
    parameter int AWL = 8
);
    logic           o_RAM_EN;
    logic           o_RAM_WrE;
    logic [AWL-1:0] o_RAM_ADDR;
    logic [DWL-1:0] i_RAM_DATA;
    logic [DWL-1:0] o_DATA;
    logic           o_VALID;
    logic           i_READY;
    logic           o_LAST;

    modport master (
        output o_RAM_EN, o_RAM_WrE, o_RAM_ADDR, o_DATA, o_VALID, o_LAST,
        input  i_RAM_DATA, i_READY
    );

    modport slave (
        input  o_RAM_EN, o_RAM_WrE, o_RAM_ADDR, o_DATA, o_VALID, o_LAST,
        output i_RAM_DATA, i_READY
    );
endinterface

// File: rtl/fft_ram_reader.sv
// Streams one 2**AWL-word frame out of a 1-cycle-latency RAM, in natural or
// bit-reversed address order, through a 2-entry skid FIFO with backpressure.
module fft_ram_reader #(
    parameter int DWL         = 16,
    parameter int AWL         = 8,
    parameter int BIT_REVERSE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_START,
    output logic              o_BUSY,
    output logic              o_DONE,
    fft_ram_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [AWL:0]   cnt_reg;
    logic           inflight_reg;
    logic           inflight_last_reg;
    logic [1:0]     occ_reg;
    logic           rd_ptr_reg, wr_ptr_reg;
    logic           done_reg;
    logic [DWL-1:0] buf_data_reg [2];
    logic           buf_last_reg [2];

    logic           valid, pop, head_last;
    logic           ram_en, last_issue;
    logic [2:0]     level;
    logic [AWL-1:0] cnt_low, cnt_rev;

    assign valid     = (occ_reg != 2'd0);
    assign pop       = valid & bus.i_READY;
    assign head_last = buf_last_reg[rd_ptr_reg];
    assign level     = {1'b0, occ_reg} + {2'b0, inflight_reg};
    assign cnt_low   = cnt_reg[AWL-1:0];

    generate
        for (genvar gi = 0; gi < AWL; gi++) begin : g_rev
            assign cnt_rev[gi] = cnt_low[AWL-1-gi];
        end
    endgenerate

    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        ram_en     = 1'b0;
        last_issue = 1'b0;
        state_next = state_reg;
        if (state_reg == READ && !cnt_reg[AWL] && level <= 3'd1 + {2'b0, pop})
            ram_en = 1'b1;
        last_issue = ram_en && (cnt_low == {AWL{1'b1}});
        case (state_reg)
            IDLE:    if (i_START) state_next = READ;
            READ:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (pop && head_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            occ_reg           <= 2'd0;
            rd_ptr_reg        <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= ram_en;
            inflight_last_reg <= last_issue;
            done_reg          <= (state_reg == DRAIN) && pop && head_last;
            if (state_reg == IDLE && i_START)
                cnt_reg <= '0;
            else if (ram_en)
                cnt_reg <= cnt_reg + (AWL+1)'(1);
            if (inflight_reg)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
    end

    // Buffer storage needs no reset: its contents are only visible while occ != 0.
    always_ff @(posedge CLK) begin
        if (inflight_reg) begin
            buf_data_reg[wr_ptr_reg] <= bus.i_RAM_DATA;
            buf_last_reg[wr_ptr_reg] <= inflight_last_reg;
        end
    end

    assign bus.o_RAM_EN   = ram_en;
    assign bus.o_RAM_WrE  = 1'b0;
    assign bus.o_RAM_ADDR = (BIT_REVERSE != 0) ? cnt_rev : cnt_low;
    assign bus.o_VALID    = valid;
    assign bus.o_DATA     = valid ? buf_data_reg[rd_ptr_reg] : '0;
    assign bus.o_LAST     = valid & head_last;
    assign o_BUSY         = (state_reg != IDLE);
    assign o_DONE         = done_reg;
endmodule

// File: tb/tb_fft_ram_reader.sv
// Directed bench for fft_ram_reader (AWL=3): natural order, bit-reversed order,
// backpressure, start-while-busy, back-to-back frames and mid-frame reset.
module tb_fft_ram_reader;
    logic clk = 1'b0;
    logic rst;
    logic start0, start1;
    logic busy0, done0, busy1, done1;
    int   checks = 0;
    int   errors = 0;

    fft_ram_reader_if #(.DWL(16), .AWL(3)) bus0 ();
    fft_ram_reader_if #(.DWL(16), .AWL(3)) bus1 ();

    fft_ram_reader #(.DWL(16), .AWL(3), .BIT_REVERSE(0)) dut0 (
        .CLK(clk), .RST(rst), .i_START(start0), .o_BUSY(busy0), .o_DONE(done0), .bus(bus0)
    );
    fft_ram_reader #(.DWL(16), .AWL(3), .BIT_REVERSE(1)) dut1 (
        .CLK(clk), .RST(rst), .i_START(start1), .o_BUSY(busy1), .o_DONE(done1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // RAM[a] = 0x11*a, one-cycle read latency; garbage when not enabled.
    always @(posedge clk) begin
        bus0.i_RAM_DATA <= bus0.o_RAM_EN ? 16'h0011 * {13'd0, bus0.o_RAM_ADDR} : 16'hDEAD;
        bus1.i_RAM_DATA <= bus1.o_RAM_EN ? 16'h0011 * {13'd0, bus1.o_RAM_ADDR} : 16'hDEAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consume a whole frame on dut0, checking order, LAST, stall stability and occupancy.
    task automatic stream(input bit toggle);
        int            idx = 0;
        bit            done_seen = 1'b0;
        bit            held;
        logic [15:0]   hold;
        bus0.i_READY = 1'b1;
        for (int n = 0; n < 80 && !done_seen; n++) begin
            if (bus0.o_VALID && bus0.i_READY) begin
                check("stream_data", {16'd0, bus0.o_DATA}, idx * 32'h11);
                check("stream_last", {31'd0, bus0.o_LAST}, {31'd0, idx == 7});
                idx++;
            end
            held = bus0.o_VALID && !bus0.i_READY;
            hold = bus0.o_DATA;
            tick();
            if (held) check("stall_hold", {16'd0, bus0.o_DATA}, {16'd0, hold});
            check("occ_le_2", {31'd0, dut0.occ_reg <= 2'd2}, 32'd1);
            if (done0) done_seen = 1'b1;
            if (toggle) bus0.i_READY = ~bus0.i_READY;
        end
        check("stream_count", idx, 8);
        check("stream_done", {31'd0, done_seen}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          issued;
        int          idx;
        bit          found;
        logic [15:0] rev_exp [8];
        rev_exp = '{16'h00, 16'h44, 16'h22, 16'h66, 16'h11, 16'h55, 16'h33, 16'h77};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        bus0.i_READY = 1'b0; bus1.i_READY = 1'b1;
        tick(); tick(); tick();
        check("rst_valid", {31'd0, bus0.o_VALID}, 32'd0);
        check("rst_data",  {16'd0, bus0.o_DATA}, 32'd0);
        check("rst_busy",  {31'd0, busy0}, 32'd0);
        check("rst_done",  {31'd0, done0}, 32'd0);
        check("rst_en",    {31'd0, bus0.o_RAM_EN}, 32'd0);
        check("rst_addr",  {29'd0, bus0.o_RAM_ADDR}, 32'd0);
        check("rst_wre",   {31'd0, bus0.o_RAM_WrE}, 32'd0);
        rst = 1'b0;

        // Natural order, ready high; start ignored at cycle 5, accepted at the DONE cycle 11.
        start0 = 1'b1; bus0.i_READY = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start0 = (c == 5 || c == 11);
            check("t1_valid", {31'd0, bus0.o_VALID}, {31'd0, c >= 3 && c <= 10});
            check("t1_last",  {31'd0, bus0.o_LAST},  {31'd0, c == 10});
            check("t1_done",  {31'd0, done0},        {31'd0, c == 11});
            check("t1_busy",  {31'd0, busy0},        {31'd0, c <= 10 || c == 12});
            check("t1_en",    {31'd0, bus0.o_RAM_EN}, {31'd0, c <= 8 || c == 12});
            check("t1_wre",   {31'd0, bus0.o_RAM_WrE}, 32'd0);
            if (c <= 8) check("t1_addr", {29'd0, bus0.o_RAM_ADDR}, c - 1);
            if (c >= 3 && c <= 10) check("t1_data", {16'd0, bus0.o_DATA}, (c - 3) * 32'h11);
        end
        start0 = 1'b0;
        tick();
        check("t2_valid13", {31'd0, bus0.o_VALID}, 32'd0);
        tick();
        check("t2_valid14", {31'd0, bus0.o_VALID}, 32'd1);
        check("t2_data14",  {16'd0, bus0.o_DATA}, 32'd0);
        stream(1'b1);

        // Ready low for 20 cycles: only two reads may be issued.
        start0 = 1'b1; bus0.i_READY = 1'b0;
        tick();
        start0 = 1'b0;
        issued = 0;
        for (int n = 0; n < 20; n++) begin
            issued += int'(bus0.o_RAM_EN);
            tick();
        end
        check("stall_issued", issued, 2);
        check("stall_valid", {31'd0, bus0.o_VALID}, 32'd1);
        check("stall_data",  {16'd0, bus0.o_DATA}, 32'd0);
        stream(1'b0);

        // Reset at the handshake of word 4.
        start0 = 1'b1; bus0.i_READY = 1'b1;
        tick();
        start0 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (bus0.o_VALID && bus0.o_DATA == 16'h44) found = 1'b1;
            else tick();
        end
        check("mid_found", {31'd0, found}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_valid", {31'd0, bus0.o_VALID}, 32'd0);
        check("mid_data",  {16'd0, bus0.o_DATA}, 32'd0);
        check("mid_last",  {31'd0, bus0.o_LAST}, 32'd0);
        check("mid_busy",  {31'd0, busy0}, 32'd0);
        check("mid_en",    {31'd0, bus0.o_RAM_EN}, 32'd0);
        check("mid_addr",  {29'd0, bus0.o_RAM_ADDR}, 32'd0);
        start0 = 1'b1;
        tick();
        check("rst_prio_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        tick();
        start0 = 1'b0;
        check("restart_busy", {31'd0, busy0}, 32'd1);
        tick(); tick();
        check("restart_valid", {31'd0, bus0.o_VALID}, 32'd1);
        stream(1'b0);

        // Bit-reversed instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        idx = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus1.o_VALID && idx < 8) begin
                check("rev_data", {16'd0, bus1.o_DATA}, {16'd0, rev_exp[idx]});
                check("rev_last", {31'd0, bus1.o_LAST}, {31'd0, idx == 7});
                idx++;
            end
            tick();
        end
        check("rev_count", idx, 8);
        check("rev_idle", {31'd0, busy1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
